lstm_node: RTL and testbench

- Single LSTM processing element for one hidden unit.
- Takes four pre-activation gate sums (input i, candidate c, forget f, output o) and the previous cell state.
- Computes the new cell state and hidden output in signed Q8.7 fixed point using a small multi-cycle FSM.
- Sits downstream of the PE/MAC array (start is signalled via status_in) and feeds the recurrent path (lstm_recu_out) back to the next time step.

---
 rtl/lstm_node.sv | 196 +++++++++++++++++++
 tb/tb_lstm_node.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/lstm_node.sv
// -----------------------------------------------------------------------------
// LstmNode: one LSTM hidden unit, signed Q8.7 fixed point.
//
// Takes the four gate pre-activation sums produced by the PE/MAC array plus the
// previous cell state. It computes the new cell state c and the hidden output
// h over a short multi-cycle sequence: IDLE -> ACT -> CELL -> OUT -> DONE.
//
// Ports:
//   clock           rising-edge clock
//   reset           asynchronous, active-high reset
//   lstm_node_in_i  input-gate pre-activation
//   lstm_node_in_c  candidate pre-activation
//   lstm_node_in_f  forget-gate pre-activation
//   lstm_node_in_o  output-gate pre-activation
//   lstm_recu_in    previous cell state c_prev (ignored with internal state)
//   status_in       PE state: 1 = START, anything else = no start
//   status_out      LSTM state: 0 IDLE, 1 ACT, 2 CELL, 3 OUT, 4 DONE
//   lstm_node_out   registered hidden output h
//   lstm_recu_out   registered new cell state c (recurrent path)
//
// Configuration macro:
//   LSTM_INTERNAL_STATE_EN - when defined, c_prev comes from an internal
//   cell-state register that is updated with c on every OUT edge, and
//   lstm_recu_in is not used.
// -----------------------------------------------------------------------------
module lstm_node #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 7
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] lstm_node_in_i,
    input  logic signed [DATA_W-1:0] lstm_node_in_c,
    input  logic signed [DATA_W-1:0] lstm_node_in_f,
    input  logic signed [DATA_W-1:0] lstm_node_in_o,
    input  logic signed [DATA_W-1:0] lstm_recu_in,
    input  logic        [1:0]        status_in,
    output logic        [2:0]        status_out,
    output logic signed [DATA_W-1:0] lstm_node_out,
    output logic signed [DATA_W-1:0] lstm_recu_out
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACT  = 3'd1,
        ST_CELL = 3'd2,
        ST_OUT  = 3'd3,
        ST_DONE = 3'd4
    } lstmState_t;

    localparam logic [1:0] PE_START = 2'd1;
    localparam int ONE      = 1 << FRAC_W;
    localparam int WORD_MAX = (1 << (DATA_W - 1)) - 1;
    localparam int WORD_MIN = -(1 << (DATA_W - 1));

    // Clamps a wide intermediate back into a signed data word.
    function automatic logic signed [DATA_W-1:0] satWord(
        input logic signed [2*DATA_W-1:0] x
    );
        if (x > WORD_MAX) begin
            return DATA_W'(WORD_MAX);
        end else if (x < WORD_MIN) begin
            return DATA_W'(WORD_MIN);
        end else begin
            return x[DATA_W-1:0];
        end
    endfunction

    // Piecewise-linear sigmoid: x/4 + 0.5, clamped to [0, 1].
    // One extra bit keeps the +0.5 offset from wrapping near full scale.
    function automatic logic signed [DATA_W-1:0] hardSigmoid(
        input logic signed [DATA_W-1:0] x
    );
        logic signed [DATA_W:0] t;
        t = $signed({x[DATA_W-1], x}) >>> 2;
        t = t + (DATA_W+1)'(ONE / 2);
        if (t < 0) begin
            return '0;
        end else if (t > ONE) begin
            return DATA_W'(ONE);
        end else begin
            return t[DATA_W-1:0];
        end
    endfunction

    // Hard tanh: clamp to [-1, 1].
    function automatic logic signed [DATA_W-1:0] hardTanh(
        input logic signed [DATA_W-1:0] x
    );
        if (x > ONE) begin
            return DATA_W'(ONE);
        end else if (x < -ONE) begin
            return DATA_W'(-ONE);
        end else begin
            return x;
        end
    endfunction

    // Fixed-point product. The arithmetic shift rounds toward -inf.
    function automatic logic signed [2*DATA_W-1:0] fixMul(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [2*DATA_W-1:0] p;
        p = (2*DATA_W)'(a) * (2*DATA_W)'(b);
        return p >>> FRAC_W;
    endfunction

    lstmState_t              r_state;
    logic signed [DATA_W-1:0] r_xI, r_xC, r_xF, r_xO, r_cPrev;
    logic signed [DATA_W-1:0] r_gi, r_gf, r_go, r_gg;
    logic signed [DATA_W-1:0] r_cell;
    logic signed [DATA_W-1:0] r_nodeOut, r_recuOut;
`ifdef LSTM_INTERNAL_STATE_EN
    logic signed [DATA_W-1:0] r_cellState;
`endif

    logic                     w_start;
    logic signed [DATA_W-1:0] w_cPrevSrc;

    assign w_start = (status_in == PE_START);

`ifdef LSTM_INTERNAL_STATE_EN
    assign w_cPrevSrc = r_cellState;
`else
    assign w_cPrevSrc = lstm_recu_in;
`endif

    // Sequencer and datapath registers.
    // DONE behaves like IDLE for start detection, which allows back-to-back
    // operation: one result every four cycles while START is held.
    // The gate products are at most one data word plus 1.0 in magnitude.
    // The 32-bit sum therefore gives the same result as a 17-bit sum.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_xI        <= '0;
            r_xC        <= '0;
            r_xF        <= '0;
            r_xO        <= '0;
            r_cPrev     <= '0;
            r_gi        <= '0;
            r_gf        <= '0;
            r_go        <= '0;
            r_gg        <= '0;
            r_cell      <= '0;
            r_nodeOut   <= '0;
            r_recuOut   <= '0;
`ifdef LSTM_INTERNAL_STATE_EN
            r_cellState <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start) begin
                        r_xI    <= lstm_node_in_i;
                        r_xC    <= lstm_node_in_c;
                        r_xF    <= lstm_node_in_f;
                        r_xO    <= lstm_node_in_o;
                        r_cPrev <= w_cPrevSrc;
                        r_state <= ST_ACT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ACT: begin
                    r_gi    <= hardSigmoid(r_xI);
                    r_gf    <= hardSigmoid(r_xF);
                    r_go    <= hardSigmoid(r_xO);
                    r_gg    <= hardTanh(r_xC);
                    r_state <= ST_CELL;
                end
                ST_CELL: begin
                    r_cell  <= satWord(fixMul(r_gf, r_cPrev) + fixMul(r_gi, r_gg));
                    r_state <= ST_OUT;
                end
                ST_OUT: begin
                    r_nodeOut   <= satWord(fixMul(r_go, hardTanh(r_cell)));
                    r_recuOut   <= r_cell;
`ifdef LSTM_INTERNAL_STATE_EN
                    r_cellState <= r_cell;
`endif
                    r_state     <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign status_out    = r_state;
    assign lstm_node_out = r_nodeOut;
    assign lstm_recu_out = r_recuOut;

endmodule

// File: tb/tb_lstm_node.sv
// -----------------------------------------------------------------------------
// Testbench for lstm_node: directed vectors with hand-computed Q8.7 results,
// plus sequences for back-to-back START, reserved status codes and an
// asynchronous reset in the middle of an operation.
// LSTM_INTERNAL_STATE_EN selects the internal cell-state sequence instead of
// the external c_prev vectors.
// -----------------------------------------------------------------------------
module tb_lstm_node;

    logic               clock;
    logic               reset;
    logic signed [15:0] inI, inC, inF, inO, recuIn;
    logic        [1:0]  statusIn;
    logic        [2:0]  statusOut;
    logic signed [15:0] nodeOut, recuOut;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        string       name;
        logic [15:0] xI, xC, xF, xO, cPrev;
        logic [15:0] expC, expH;
    } vector_t;

    lstm_node #(.DATA_W(16), .FRAC_W(7)) dut (
        .clock          (clock),
        .reset          (reset),
        .lstm_node_in_i (inI),
        .lstm_node_in_c (inC),
        .lstm_node_in_f (inF),
        .lstm_node_in_o (inO),
        .lstm_recu_in   (recuIn),
        .status_in      (statusIn),
        .status_out     (statusOut),
        .lstm_node_out  (nodeOut),
        .lstm_recu_out  (recuOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkValue(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
        end
    endtask

    // Pulse START for one edge, then scramble the inputs while the node is busy
    // so that only captured values can produce the expected result.
    task automatic applyStimulus(input vector_t v, output int latency);
        @(negedge clock);
        inI = v.xI; inC = v.xC; inF = v.xF; inO = v.xO; recuIn = v.cPrev;
        statusIn = 2'd1;
        @(posedge clock);
        #1;
        checkValue({v.name, " state ACT"}, 16'(statusOut), 16'd1);
        inI = ~v.xI; inC = ~v.xC; inF = ~v.xF; inO = ~v.xO; recuIn = ~v.cPrev;
        statusIn = 2'd3;
        latency = 0;
        while (statusOut != 3'd4 && latency < 10) begin
            @(posedge clock);
            #1;
            latency++;
        end
        statusIn = 2'd0;
    endtask

    task automatic checkOutput(input vector_t v, input int latency);
        checkValue({v.name, " latency"}, 16'(latency), 16'd3);
        checkValue({v.name, " recu_out"}, recuOut, v.expC);
        checkValue({v.name, " node_out"}, nodeOut, v.expH);
        @(posedge clock);
        #1;
        checkValue({v.name, " back to IDLE"}, 16'(statusOut), 16'd0);
        checkValue({v.name, " recu hold"}, recuOut, v.expC);
    endtask

    initial begin
        vector_t     vectors[7];
        int          lat;
        logic [15:0] lastC, lastH;

        vectors[0] = '{"basic",    16'h0014, 16'h0014, 16'h0014, 16'h0014, 16'h0014, 16'h0014, 16'h000A};
        vectors[1] = '{"sat pos",  16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0080};
        vectors[2] = '{"negative", 16'h0000, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'hFFC0, 16'hFFE0};
        vectors[3] = '{"mixed",    16'h0080, 16'h0040, 16'hFF00, 16'h0100, 16'h1000, 16'h0030, 16'h0030};
        vectors[4] = '{"sat neg",  16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h8000, 16'h8000, 16'h0000};
        vectors[5] = '{"floor",    16'h0004, 16'hFFFF, 16'hFE00, 16'h0000, 16'h0100, 16'hFFFF, 16'hFFFF};
        vectors[6] = '{"tanh clip",16'h01FC, 16'h0050, 16'h01FC, 16'h0000, 16'h0400, 16'h0450, 16'h0040};

        reset = 1'b1;
        statusIn = 2'd0;
        inI = '0; inC = '0; inF = '0; inO = '0; recuIn = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkValue("reset state", 16'(statusOut), 16'd0);
        checkValue("reset node_out", nodeOut, 16'h0000);
        checkValue("reset recu_out", recuOut, 16'h0000);

`ifndef LSTM_INTERNAL_STATE_EN
        // START held from reset release: sequence 1,2,3,4 repeating.
        inI = 16'h0014; inC = 16'h0014; inF = 16'h0014; inO = 16'h0014; recuIn = 16'h0014;
        statusIn = 2'd1;
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clock);
            #1;
            checkValue($sformatf("held state edge %0d", k), 16'(statusOut), 16'(((k - 1) % 4) + 1));
            if (k == 3) begin
                checkValue("held node_out before OUT", nodeOut, 16'h0000);
                checkValue("held recu_out before OUT", recuOut, 16'h0000);
            end
            if (k % 4 == 0) begin
                checkValue($sformatf("held recu_out edge %0d", k), recuOut, 16'h0014);
                checkValue($sformatf("held node_out edge %0d", k), nodeOut, 16'h000A);
            end
        end
        statusIn = 2'd0;
        @(posedge clock);
        #1;
        checkValue("held release to IDLE", 16'(statusOut), 16'd0);

        for (int n = 0; n < 7; n++) begin
            applyStimulus(vectors[n], lat);
            checkOutput(vectors[n], lat);
        end
        lastC = vectors[6].expC;
        lastH = vectors[6].expH;
`else
        // Internal cell state: c_prev follows the previous result.
        begin
            logic [15:0] expC[4];
            logic [15:0] expH[4];
            expC = '{16'h000A, 16'h000F, 16'h0012, 16'h0013};
            expH = '{16'h0005, 16'h0008, 16'h0009, 16'h000A};
            inI = 16'h0014; inC = 16'h0014; inF = 16'h0014; inO = 16'h0014;
            recuIn = 16'h1234;
            statusIn = 2'd1;
            reset = 1'b0;
            for (int r = 0; r < 4; r++) begin
                repeat (4) @(posedge clock);
                #1;
                checkValue($sformatf("internal run %0d state", r), 16'(statusOut), 16'd4);
                checkValue($sformatf("internal run %0d recu_out", r), recuOut, expC[r]);
                checkValue($sformatf("internal run %0d node_out", r), nodeOut, expH[r]);
            end
            statusIn = 2'd0;
            @(posedge clock);
            #1;
            checkValue("internal release to IDLE", 16'(statusOut), 16'd0);
            lastC = expC[3];
            lastH = expH[3];
        end
`endif

        // Non-start status codes leave the node idle with outputs untouched.
        for (int s = 0; s < 4; s++) begin
            if (s != 1) begin
                @(negedge clock);
                statusIn = 2'(s);
                inI = 16'h0100; inC = 16'h0100; inF = 16'h0100; inO = 16'h0100;
                repeat (2) @(posedge clock);
                #1;
                checkValue($sformatf("status_in %0d state", s), 16'(statusOut), 16'd0);
                checkValue($sformatf("status_in %0d recu hold", s), recuOut, lastC);
                checkValue($sformatf("status_in %0d node hold", s), nodeOut, lastH);
            end
        end

        // Asynchronous reset while the node is in CELL.
        @(negedge clock);
        inI = 16'h0014; inC = 16'h0014; inF = 16'h0014; inO = 16'h0014; recuIn = 16'h0014;
        statusIn = 2'd1;
        @(posedge clock);
        #1;
        statusIn = 2'd0;
        @(posedge clock);
        #1;
        checkValue("mid-run state CELL", 16'(statusOut), 16'd2);
        #1;
        reset = 1'b1;
        #1;
        checkValue("async reset state", 16'(statusOut), 16'd0);
        checkValue("async reset node_out", nodeOut, 16'h0000);
        checkValue("async reset recu_out", recuOut, 16'h0000);
        @(negedge clock);
        reset = 1'b0;
        repeat (6) begin
            @(posedge clock);
            #1;
            checkValue("post-reset idle", 16'(statusOut), 16'd0);
        end
        checkValue("post-reset node_out", nodeOut, 16'h0000);
        checkValue("post-reset recu_out", recuOut, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
